// File: rtl/qpu_evt_time_sched_pkg.sv
// Shared widths and types for the timed event scheduler.
// The width defaults mirror QPU_TIME_WIDTH, QPU_EVENT_WIRE_WIDTH, QPU_EVENT_NUM and QPU_EVT_Q_DEPTH.
package qpu_evt_time_sched_pkg;

    localparam int unsigned QPU_TIME_WIDTH       = 32;
    localparam int unsigned QPU_EVENT_WIRE_WIDTH = 48;
    localparam int unsigned QPU_EVENT_NUM        = 8;
    localparam int unsigned QPU_EVT_Q_DEPTH      = 4;

    // Outcome of the head-of-queue timestamp compare in a given cycle.
    typedef enum logic [1:0] {
        FIRE_NONE    = 2'd0,
        FIRE_ON_TIME = 2'd1,
        FIRE_LATE    = 2'd2
    } fire_e;

endpackage

// File: rtl/qpu_evt_time_sched_if.sv
// Writeback inputs (timing point, event) and the fired-event outputs of the scheduler.
interface qpu_evt_time_sched_if
    import qpu_evt_time_sched_pkg::*;
#(
    parameter int unsigned TIME_W  = QPU_TIME_WIDTH,
    parameter int unsigned EDATA_W = QPU_EVENT_WIRE_WIDTH,
    parameter int unsigned EOPR_W  = QPU_EVENT_NUM
) ();

    logic               twbck_i_valid;
    logic               twbck_i_ready;
    logic [TIME_W-1:0]  twbck_i_data;

    logic               ewbck_i_valid;
    logic               ewbck_i_ready;
    logic [EDATA_W-1:0] ewbck_i_data;
    logic [EOPR_W-1:0]  ewbck_i_oprand;

    logic               evt_o_valid;
    logic [TIME_W-1:0]  evt_o_time;
    logic [EDATA_W-1:0] evt_o_data;
    logic [EOPR_W-1:0]  evt_o_oprand;

    modport master (
        output twbck_i_valid, twbck_i_data,
        output ewbck_i_valid, ewbck_i_data, ewbck_i_oprand,
        input  twbck_i_ready, ewbck_i_ready,
        input  evt_o_valid, evt_o_time, evt_o_data, evt_o_oprand
    );

    modport slave (
        input  twbck_i_valid, twbck_i_data,
        input  ewbck_i_valid, ewbck_i_data, ewbck_i_oprand,
        output twbck_i_ready, ewbck_i_ready,
        output evt_o_valid, evt_o_time, evt_o_data, evt_o_oprand
    );

endinterface

// File: rtl/qpu_evt_time_sched_fifo.sv
// Event queue storage: circular buffer with wrap-bit pointers, combinational head read.
module qpu_evt_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    // Pointers differing only in the wrap bit means every slot is occupied.
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clr_i) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/qpu_evt_time_sched.sv
// Timed event scheduler: owns the system timer, tags queued events with absolute
// timestamps and releases each one in the cycle the timer reaches its time.
module qpu_evt_time_sched
    import qpu_evt_time_sched_pkg::*;
#(
    parameter int unsigned TIME_W  = QPU_TIME_WIDTH,
    parameter int unsigned EDATA_W = QPU_EVENT_WIRE_WIDTH,
    parameter int unsigned EOPR_W  = QPU_EVENT_NUM,
    parameter int unsigned DEPTH   = QPU_EVT_Q_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sync_clr,
    input  logic              tmr_en,
    qpu_evt_time_sched_if.slave bus,
    output logic [TIME_W-1:0] sys_time,
    output logic              q_empty,
    output logic              q_full,
    output logic              late_err
);

    localparam int unsigned EW = TIME_W + EDATA_W + EOPR_W;

    logic [TIME_W-1:0]  sys_time_q, sys_time_d;
    logic [TIME_W-1:0]  time_q, time_d;
    logic [TIME_W-1:0]  tag_time, head_time, delta;
    logic [EDATA_W-1:0] head_data;
    logic [EOPR_W-1:0]  head_opr;
    logic [EW-1:0]      push_entry, head_entry;
    logic               push, pop, fifo_full, fifo_empty;
    fire_e              fire;

    logic               evt_valid_q;
    logic [TIME_W-1:0]  evt_time_q;
    logic [EDATA_W-1:0] evt_data_q;
    logic [EOPR_W-1:0]  evt_opr_q;
    logic               late_q;

    always_comb begin
        sys_time_d = sys_time_q;
        if (sync_clr)    sys_time_d = '0;
        else if (tmr_en) sys_time_d = sys_time_q + TIME_W'(1);
    end

    always_comb begin
        time_d = time_q;
        if (sync_clr)               time_d = '0;
        else if (bus.twbck_i_valid) time_d = bus.twbck_i_data;
    end

    // A timing point written alongside an event tags that event directly.
    assign tag_time   = bus.twbck_i_valid ? bus.twbck_i_data : time_q;
    assign push_entry = {tag_time, bus.ewbck_i_data, bus.ewbck_i_oprand};
    assign push       = bus.ewbck_i_valid & ~fifo_full & ~sync_clr;

    qpu_evt_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (sync_clr),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (push_entry),
        .rdata_o (head_entry),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign {head_time, head_data, head_opr} = head_entry;

    // Compare against next cycle's timer so the registered output lands on the timestamp;
    // a negative modular distance means the time has already passed.
    assign delta = head_time - sys_time_d;

    always_comb begin
        fire = FIRE_NONE;
        if (!fifo_empty && !sync_clr) begin
            if (delta == '0)            fire = FIRE_ON_TIME;
            else if (delta[TIME_W-1])   fire = FIRE_LATE;
        end
    end

    assign pop = (fire != FIRE_NONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sys_time_q  <= '0;
            time_q      <= '0;
            evt_valid_q <= 1'b0;
            evt_time_q  <= '0;
            evt_data_q  <= '0;
            evt_opr_q   <= '0;
            late_q      <= 1'b0;
        end else begin
            sys_time_q  <= sys_time_d;
            time_q      <= time_d;
            evt_valid_q <= pop;
            evt_time_q  <= pop ? head_time : '0;
            evt_data_q  <= pop ? head_data : '0;
            evt_opr_q   <= pop ? head_opr  : '0;
            late_q      <= sync_clr ? 1'b0 : (late_q | (fire == FIRE_LATE));
        end
    end

    assign bus.twbck_i_ready = 1'b1;
    assign bus.ewbck_i_ready = ~fifo_full;
    assign bus.evt_o_valid   = evt_valid_q;
    assign bus.evt_o_time    = evt_time_q;
    assign bus.evt_o_data    = evt_data_q;
    assign bus.evt_o_oprand  = evt_opr_q;

    assign sys_time = sys_time_q;
    assign q_empty  = fifo_empty;
    assign q_full   = fifo_full;
    assign late_err = late_q;

endmodule

// File: tb/tb_qpu_evt_time_sched.sv
// Directed bench for qpu_evt_time_sched: a 32-bit instance for the main scenarios and an
// 8-bit instance for timer wrap.
module tb_qpu_evt_time_sched;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sync_clr = 1'b0;
    logic tmr_en = 1'b0;
    logic sync_clr_w = 1'b0;
    logic tmr_en_w = 1'b0;

    logic [31:0] sys_time;
    logic        q_empty, q_full, late_err;
    logic [7:0]  sys_time_w;
    logic        q_empty_w, q_full_w, late_err_w;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    qpu_evt_time_sched_if #(.TIME_W(32), .EDATA_W(48), .EOPR_W(8)) bus ();
    qpu_evt_time_sched_if #(.TIME_W(8),  .EDATA_W(48), .EOPR_W(8)) bus_w ();

    qpu_evt_time_sched #(.TIME_W(32), .EDATA_W(48), .EOPR_W(8), .DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .sync_clr(sync_clr), .tmr_en(tmr_en), .bus(bus),
        .sys_time(sys_time), .q_empty(q_empty), .q_full(q_full), .late_err(late_err)
    );

    qpu_evt_time_sched #(.TIME_W(8), .EDATA_W(48), .EOPR_W(8), .DEPTH(4)) dut_w (
        .clk(clk), .rst_n(rst_n), .sync_clr(sync_clr_w), .tmr_en(tmr_en_w), .bus(bus_w),
        .sys_time(sys_time_w), .q_empty(q_empty_w), .q_full(q_full_w), .late_err(late_err_w)
    );

    function automatic logic [47:0] ev(input int k);
        return 48'hA5A5_0000_0000 | 48'(k);
    endfunction

    function automatic logic [7:0] opr(input int k);
        return 8'(k * 3 + 1);
    endfunction

    task automatic idle();
        bus.twbck_i_valid  = 1'b0;
        bus.twbck_i_data   = '0;
        bus.ewbck_i_valid  = 1'b0;
        bus.ewbck_i_data   = '0;
        bus.ewbck_i_oprand = '0;
    endtask

    task automatic idle_w();
        bus_w.twbck_i_valid  = 1'b0;
        bus_w.twbck_i_data   = '0;
        bus_w.ewbck_i_valid  = 1'b0;
        bus_w.ewbck_i_data   = '0;
        bus_w.ewbck_i_oprand = '0;
    endtask

    task automatic push_ev(input bit with_t, input logic [31:0] t, input int k);
        bus.twbck_i_valid  = with_t;
        bus.twbck_i_data   = t;
        bus.ewbck_i_valid  = 1'b1;
        bus.ewbck_i_data   = ev(k);
        bus.ewbck_i_oprand = opr(k);
    endtask

    task automatic do_clr();
        sync_clr = 1'b1;
        @(negedge clk);
        sync_clr = 1'b0;
    endtask

    task automatic wait_sys(input logic [31:0] t, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (sys_time === t) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        idle_w();
        repeat (2) @(negedge clk);
        checks++; if (sys_time !== 32'd0) $display("FAIL reset_sys_time got %0d exp 0", sys_time); else passed++;
        checks++; if (bus.evt_o_valid !== 1'b0 || bus.evt_o_data !== 48'd0 || bus.evt_o_oprand !== 8'd0)
            $display("FAIL reset_evt got v=%b d=%h o=%h exp all 0", bus.evt_o_valid, bus.evt_o_data, bus.evt_o_oprand); else passed++;
        checks++; if ({q_empty, q_full, late_err} !== 3'b100) $display("FAIL reset_flags got e/f/l=%b exp 100", {q_empty, q_full, late_err}); else passed++;
        checks++; if ({bus.twbck_i_ready, bus.ewbck_i_ready} !== 2'b11) $display("FAIL reset_ready got %b exp 11", {bus.twbck_i_ready, bus.ewbck_i_ready}); else passed++;
        checks++; if (sys_time_w !== 8'd0 || q_empty_w !== 1'b1) $display("FAIL reset_w got t=%0d e=%b exp 0/1", sys_time_w, q_empty_w); else passed++;
        rst_n  = 1'b1;
        tmr_en = 1'b1;
    endtask

    task automatic test_ontime();
        bit   ok;
        logic exp_v;
        wait_sys(32'd5, ok);
        checks++; if (!ok) $display("FAIL ontime_wait got timeout exp sys_time 5"); else passed++;
        push_ev(1'b1, 32'd20, 1);
        @(negedge clk);
        idle();
        checks++; if (q_empty !== 1'b0) $display("FAIL ontime_queued got q_empty=%b exp 0", q_empty); else passed++;
        repeat (17) begin
            exp_v = (sys_time == 32'd20);
            checks++; if (bus.evt_o_valid !== exp_v) $display("FAIL ontime_valid t=%0d got %b exp %b", sys_time, bus.evt_o_valid, exp_v); else passed++;
            if (exp_v) begin
                checks++; if (bus.evt_o_data !== ev(1) || bus.evt_o_oprand !== opr(1) || bus.evt_o_time !== 32'd20 || late_err !== 1'b0)
                    $display("FAIL ontime_payload got d=%h o=%h t=%0d l=%b exp d=%h o=%h t=20 l=0", bus.evt_o_data, bus.evt_o_oprand, bus.evt_o_time, late_err, ev(1), opr(1)); else passed++;
            end else begin
                checks++; if (bus.evt_o_data !== 48'd0 || bus.evt_o_oprand !== 8'd0)
                    $display("FAIL ontime_idle_zero t=%0d got d=%h o=%h exp 0", sys_time, bus.evt_o_data, bus.evt_o_oprand); else passed++;
            end
            @(negedge clk);
        end
        checks++; if (q_empty !== 1'b1 || late_err !== 1'b0) $display("FAIL ontime_after got e=%b l=%b exp 1/0", q_empty, late_err); else passed++;
    endtask

    task automatic test_full_burst();
        logic exp_v;
        do_clr();
        checks++; if (sys_time !== 32'd0) $display("FAIL burst_clr_time got %0d exp 0", sys_time); else passed++;
        bus.twbck_i_valid = 1'b1;
        bus.twbck_i_data  = 32'd30;
        @(negedge clk);
        idle();
        for (int k = 1; k <= 4; k++) begin
            if (k == 4) begin
                checks++; if (q_full !== 1'b0 || bus.ewbck_i_ready !== 1'b1) $display("FAIL burst_three got f=%b r=%b exp 0/1", q_full, bus.ewbck_i_ready); else passed++;
            end
            push_ev(1'b0, 32'd0, k);
            @(negedge clk);
        end
        checks++; if (q_full !== 1'b1 || bus.ewbck_i_ready !== 1'b0) $display("FAIL burst_full got f=%b r=%b exp 1/0", q_full, bus.ewbck_i_ready); else passed++;
        push_ev(1'b0, 32'd0, 5);
        repeat (2) @(negedge clk);
        idle();
        checks++; if (q_full !== 1'b1) $display("FAIL burst_held got q_full=%b exp 1", q_full); else passed++;
        repeat (30) begin
            exp_v = (sys_time >= 32'd30) && (sys_time <= 32'd33);
            checks++; if (bus.evt_o_valid !== exp_v) $display("FAIL burst_valid t=%0d got %b exp %b", sys_time, bus.evt_o_valid, exp_v); else passed++;
            if (exp_v) begin
                checks++; if (bus.evt_o_data !== ev(int'(sys_time) - 29) || bus.evt_o_time !== 32'd30)
                    $display("FAIL burst_data t=%0d got d=%h ts=%0d exp d=%h ts=30", sys_time, bus.evt_o_data, bus.evt_o_time, ev(int'(sys_time) - 29)); else passed++;
            end
            checks++; if (late_err !== (sys_time >= 32'd31)) $display("FAIL burst_late t=%0d got %b exp %b", sys_time, late_err, (sys_time >= 32'd31)); else passed++;
            @(negedge clk);
        end
        checks++; if (q_empty !== 1'b1) $display("FAIL burst_drained got q_empty=%b exp 1", q_empty); else passed++;
    endtask

    task automatic test_late();
        bit   ok;
        logic exp_v;
        do_clr();
        wait_sys(32'd50, ok);
        checks++; if (!ok) $display("FAIL late_wait got timeout exp sys_time 50"); else passed++;
        push_ev(1'b1, 32'd10, 6);
        @(negedge clk);
        idle();
        checks++; if (bus.evt_o_valid !== 1'b0 || late_err !== 1'b0) $display("FAIL late_early got v=%b l=%b exp 0/0", bus.evt_o_valid, late_err); else passed++;
        @(negedge clk);
        checks++; if (bus.evt_o_valid !== 1'b1 || bus.evt_o_data !== ev(6) || bus.evt_o_time !== 32'd10 || late_err !== 1'b1)
            $display("FAIL late_fire t=%0d got v=%b d=%h ts=%0d l=%b exp 1 %h 10 1", sys_time, bus.evt_o_valid, bus.evt_o_data, bus.evt_o_time, late_err, ev(6)); else passed++;
        @(negedge clk);
        push_ev(1'b1, 32'd60, 7);
        @(negedge clk);
        idle();
        repeat (9) begin
            exp_v = (sys_time == 32'd60);
            checks++; if (bus.evt_o_valid !== exp_v) $display("FAIL late_second_valid t=%0d got %b exp %b", sys_time, bus.evt_o_valid, exp_v); else passed++;
            if (exp_v) begin
                checks++; if (bus.evt_o_data !== ev(7) || bus.evt_o_time !== 32'd60) $display("FAIL late_second_data got d=%h ts=%0d exp %h 60", bus.evt_o_data, bus.evt_o_time, ev(7)); else passed++;
            end
            checks++; if (late_err !== 1'b1) $display("FAIL late_sticky t=%0d got %b exp 1", sys_time, late_err); else passed++;
            @(negedge clk);
        end
    endtask

    task automatic test_sync_clr();
        logic [31:0] t0;
        push_ev(1'b1, 32'd200, 8);
        @(negedge clk);
        push_ev(1'b0, 32'd0, 9);
        @(negedge clk);
        idle();
        checks++; if (q_empty !== 1'b0 || q_full !== 1'b0 || late_err !== 1'b1) $display("FAIL clr_before got e=%b f=%b l=%b exp 0 0 1", q_empty, q_full, late_err); else passed++;
        sync_clr = 1'b1;
        push_ev(1'b1, 32'd5, 10);
        @(negedge clk);
        sync_clr = 1'b0;
        idle();
        checks++; if (sys_time !== 32'd0) $display("FAIL clr_time got %0d exp 0", sys_time); else passed++;
        checks++; if (q_empty !== 1'b1 || late_err !== 1'b0 || bus.evt_o_valid !== 1'b0)
            $display("FAIL clr_state got e=%b l=%b v=%b exp 1 0 0", q_empty, late_err, bus.evt_o_valid); else passed++;
        repeat (5) begin
            checks++; if (bus.evt_o_valid !== 1'b0 || q_empty !== 1'b1) $display("FAIL clr_quiet t=%0d got v=%b e=%b exp 0/1", sys_time, bus.evt_o_valid, q_empty); else passed++;
            @(negedge clk);
        end
        t0 = sys_time;
        push_ev(1'b0, 32'd0, 11);
        @(negedge clk);
        idle();
        @(negedge clk);
        checks++; if (bus.evt_o_valid !== 1'b1 || bus.evt_o_time !== 32'd0 || late_err !== 1'b1)
            $display("FAIL clr_timereg got v=%b ts=%0d l=%b exp 1 0 1 (pushed at %0d)", bus.evt_o_valid, bus.evt_o_time, late_err, t0); else passed++;
    endtask

    task automatic test_wrap();
        bit   ok;
        logic exp_v;
        int   fires;
        ok = 1'b0;
        fires = 0;
        tmr_en_w = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (sys_time_w === 8'd250) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++; if (!ok) $display("FAIL wrap_wait got timeout exp sys_time_w 250"); else passed++;
        bus_w.twbck_i_valid  = 1'b1;
        bus_w.twbck_i_data   = 8'd3;
        bus_w.ewbck_i_valid  = 1'b1;
        bus_w.ewbck_i_data   = ev(12);
        bus_w.ewbck_i_oprand = opr(12);
        @(negedge clk);
        idle_w();
        repeat (12) begin
            exp_v = (sys_time_w == 8'd3);
            checks++; if (bus_w.evt_o_valid !== exp_v) $display("FAIL wrap_valid t=%0d got %b exp %b", sys_time_w, bus_w.evt_o_valid, exp_v); else passed++;
            if (exp_v) begin
                fires++;
                checks++; if (bus_w.evt_o_data !== ev(12) || bus_w.evt_o_time !== 8'd3) $display("FAIL wrap_data got d=%h ts=%0d exp %h 3", bus_w.evt_o_data, bus_w.evt_o_time, ev(12)); else passed++;
            end
            checks++; if (late_err_w !== 1'b0) $display("FAIL wrap_late t=%0d got %b exp 0", sys_time_w, late_err_w); else passed++;
            @(negedge clk);
        end
        checks++; if (fires != 1 || q_empty_w !== 1'b1) $display("FAIL wrap_count got fires=%0d e=%b exp 1/1", fires, q_empty_w); else passed++;
    endtask

    task automatic test_async_reset();
        bit ok;
        do_clr();
        repeat (2) @(negedge clk);
        push_ev(1'b1, 32'd10, 13);
        @(negedge clk);
        push_ev(1'b0, 32'd0, 14);
        @(negedge clk);
        push_ev(1'b0, 32'd0, 15);
        @(negedge clk);
        idle();
        wait_sys(32'd10, ok);
        checks++; if (!ok) $display("FAIL arst_wait got timeout exp sys_time 10"); else passed++;
        checks++; if (bus.evt_o_valid !== 1'b1 || bus.evt_o_data !== ev(13)) $display("FAIL arst_first got v=%b d=%h exp 1 %h", bus.evt_o_valid, bus.evt_o_data, ev(13)); else passed++;
        @(negedge clk);
        checks++; if (bus.evt_o_valid !== 1'b1 || bus.evt_o_data !== ev(14) || late_err !== 1'b1)
            $display("FAIL arst_second got v=%b d=%h l=%b exp 1 %h 1", bus.evt_o_valid, bus.evt_o_data, late_err, ev(14)); else passed++;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (sys_time !== 32'd0) $display("FAIL arst_time got %0d exp 0", sys_time); else passed++;
        checks++; if (bus.evt_o_valid !== 1'b0 || bus.evt_o_data !== 48'd0 || bus.evt_o_oprand !== 8'd0 || bus.evt_o_time !== 32'd0)
            $display("FAIL arst_evt got v=%b d=%h o=%h ts=%0d exp all 0", bus.evt_o_valid, bus.evt_o_data, bus.evt_o_oprand, bus.evt_o_time); else passed++;
        checks++; if ({q_empty, q_full, late_err} !== 3'b100) $display("FAIL arst_flags got e/f/l=%b exp 100", {q_empty, q_full, late_err}); else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) begin
            checks++; if (bus.evt_o_valid !== 1'b0 || q_empty !== 1'b1) $display("FAIL arst_quiet t=%0d got v=%b e=%b exp 0/1", sys_time, bus.evt_o_valid, q_empty); else passed++;
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_ontime();
        test_full_burst();
        test_late();
        test_sync_clr();
        test_wrap();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got time limit exp end of sequence");
        $fatal(1, "timeout");
    end

endmodule
